// File: rtl/bias_bank_array.sv
// Double-buffered bias store: packages are loaded into a shadow bank while the active bank drives
// the PE array. Define BIAS_PINGPONG_EN for two banks; otherwise a single bank is written in place.
module bias_bank_array #(
  parameter int unsigned FW = 16,
  parameter int unsigned DW = 256,
  parameter int unsigned RL = 512,
  parameter int unsigned CW = $clog2(RL / (DW / FW) + 1)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             start_i,
  input  logic [CW-1:0]    pkg_num_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [DW-1:0]    data_i,
  input  logic             swap_i,
  output logic             loaded_o,
  output logic             err_o,
  output logic [RL*FW-1:0] bias_o
);

  localparam int unsigned PL = DW / FW;
  localparam int unsigned PN = RL / PL;
  localparam int unsigned BW = RL * FW;

  typedef enum logic [1:0] {StIdle, StLoad, StFull} state_e;

  state_e        state_q;
  logic [CW-1:0] wr_ptr_q, pkg_cnt_q;
  logic          ready_q, loaded_q, err_q;

  logic start_ok, start_bad, swap_ok, swap_bad, beat, last_beat;
  logic [31:0] wr_base;

  assign start_ok  = start_i && (pkg_num_i != '0) && (pkg_num_i <= CW'(PN));
  assign start_bad = start_i && !start_ok;
  assign swap_ok   = swap_i && (state_q == StFull);
  assign swap_bad  = swap_i && (state_q != StFull);
  assign beat      = valid_i && (state_q == StLoad);
  assign last_beat = (wr_ptr_q == pkg_cnt_q - CW'(1));
  assign wr_base   = 32'(wr_ptr_q) * DW;

  assign ready_o  = ready_q;
  assign loaded_o = loaded_q;
  assign err_o    = err_q;

  // Start takes priority over a same-cycle beat; start after swap in FULL restarts a load.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      pkg_cnt_q <= '0;
      ready_q   <= 1'b0;
      loaded_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= start_bad | swap_bad;
      if (start_ok) begin
        state_q   <= StLoad;
        wr_ptr_q  <= '0;
        pkg_cnt_q <= pkg_num_i;
        ready_q   <= 1'b1;
        loaded_q  <= 1'b0;
      end else if (swap_ok) begin
        state_q  <= StIdle;
        ready_q  <= 1'b0;
        loaded_q <= 1'b0;
      end else if (beat) begin
        wr_ptr_q <= wr_ptr_q + CW'(1);
        if (last_beat) begin
          state_q  <= StFull;
          ready_q  <= 1'b0;
          loaded_q <= 1'b1;
        end
      end
    end
  end

`ifdef BIAS_PINGPONG_EN
  logic                 act_bank_q;
  logic                 act_bank_d;
  logic [1:0][BW-1:0]   bank_q, bank_d;

  assign act_bank_d = act_bank_q ^ swap_ok;

  // A start coinciding with a swap clears the bank that was active until this edge.
  always_comb begin
    bank_d = bank_q;
    if (start_ok) begin
      bank_d[~act_bank_d] = '0;
    end else if (beat) begin
      bank_d[~act_bank_q][wr_base +: DW] = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      act_bank_q <= 1'b0;
      bank_q     <= '0;
    end else begin
      act_bank_q <= act_bank_d;
      bank_q     <= bank_d;
    end
  end

  assign bias_o = bank_q[act_bank_q];
`else
  logic [BW-1:0] bank_q, bank_d;

  always_comb begin
    bank_d = bank_q;
    if (start_ok) begin
      bank_d = '0;
    end else if (beat) begin
      bank_d[wr_base +: DW] = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      bank_q <= '0;
    end else begin
      bank_q <= bank_d;
    end
  end

  assign bias_o = bank_q;
`endif

endmodule

// File: tb/tb_bias_bank_array.sv
// Directed bench for bias_bank_array; expectations follow BIAS_PINGPONG_EN if it is defined.
module tb_bias_bank_array;

  localparam int unsigned FW = 16;
  localparam int unsigned DW = 256;
  localparam int unsigned RL = 64;
  localparam int unsigned CW = 3;
  localparam int unsigned BW = RL * FW;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          start_i;
  logic [CW-1:0] pkg_num_i;
  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] data_i;
  logic          swap_i;
  logic          loaded_o;
  logic          err_o;
  logic [BW-1:0] bias_o;

  int checks = 0;
  int failures = 0;

  logic [BW-1:0] e1, e2, e3, e4, part, eb, zero;
  logic          pp;

  bias_bank_array #(.FW(FW), .DW(DW), .RL(RL), .CW(CW)) dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .start_i   (start_i),
    .pkg_num_i (pkg_num_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data_i    (data_i),
    .swap_i    (swap_i),
    .loaded_o  (loaded_o),
    .err_o     (err_o),
    .bias_o    (bias_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    int idx;
    checks++;
    if (got !== exp) begin
      failures++;
      idx = 0;
      for (int i = RL - 1; i >= 0; i--) if (got[i*FW +: FW] !== exp[i*FW +: FW]) idx = i;
      $display("FAIL %s: value %0d got %h expected %h (low word got %h expected %h)", tag, idx,
               got[idx*FW +: FW], exp[idx*FW +: FW], got[15:0], exp[15:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
`ifdef BIAS_PINGPONG_EN
    pp = 1'b1;
`else
    pp = 1'b0;
`endif
    zero = '0;
    for (int i = 0; i < RL; i++) begin
      e1[i*FW +: FW] = 16'(i + 1);
      e2[i*FW +: FW] = (i < 32) ? 16'hAAAA : 16'h0000;
      e3[i*FW +: FW] = 16'(16'h1000 + i);
      e4[i*FW +: FW] = (i < 16) ? 16'(16'h2000 + i) : 16'h0000;
    end

    rstn_i = 1'b0; start_i = 1'b0; pkg_num_i = '0; valid_i = 1'b0; data_i = '0; swap_i = 1'b0;
    repeat (2) tick();
    rstn_i = 1'b1;
    repeat (5) tick();
    check("rst_bias", bias_o, zero);
    check("rst_ready", BW'(ready_o), BW'(0));
    check("rst_loaded", BW'(loaded_o), BW'(0));
    check("rst_err", BW'(err_o), BW'(0));

    // Full load of 4 packages with valid gapped every other cycle.
    start_i = 1'b1; pkg_num_i = 3'd4; tick(); start_i = 1'b0;
    check("load1_ready", BW'(ready_o), BW'(1));
    part = '0;
    for (int b = 0; b < 4; b++) begin
      valid_i = 1'b1; data_i = e1[b*DW +: DW]; tick(); valid_i = 1'b0;
      part[b*DW +: DW] = e1[b*DW +: DW];
      check("load1_bias", bias_o, pp ? zero : part);
      check("load1_loaded", BW'(loaded_o), BW'(b == 3));
      tick();
    end
    check("load1_ready_full", BW'(ready_o), BW'(0));
    swap_i = 1'b1; tick(); swap_i = 1'b0;
    check("swap1_bias", bias_o, e1);
    check("swap1_loaded", BW'(loaded_o), BW'(0));

    // Partial load of 2 packages while e1 is active.
    start_i = 1'b1; pkg_num_i = 3'd2; tick(); start_i = 1'b0;
    check("load2_start_bias", bias_o, pp ? e1 : zero);
    valid_i = 1'b1; data_i = {16{16'hAAAA}};
    tick(); tick(); valid_i = 1'b0;
    check("load2_loaded", BW'(loaded_o), BW'(1));
    check("load2_hold", bias_o, pp ? e1 : e2);
    swap_i = 1'b1; tick(); swap_i = 1'b0;
    check("swap2_bias", bias_o, e2);

    // Protocol errors during a load.
    eb = pp ? e2 : zero;
    start_i = 1'b1; pkg_num_i = 3'd4; tick(); start_i = 1'b0;
    swap_i = 1'b1; tick(); swap_i = 1'b0;
    check("err_swap_load", BW'(err_o), BW'(1));
    check("err_swap_ready", BW'(ready_o), BW'(1));
    check("err_swap_bias", bias_o, eb);
    tick();
    check("err_one_cycle", BW'(err_o), BW'(0));
    start_i = 1'b1; pkg_num_i = 3'd0; tick(); start_i = 1'b0;
    check("err_pkg0", BW'(err_o), BW'(1));
    check("err_pkg0_ready", BW'(ready_o), BW'(1));
    check("err_pkg0_bias", bias_o, eb);
    start_i = 1'b1; pkg_num_i = 3'd5; tick(); start_i = 1'b0;
    check("err_pkg5", BW'(err_o), BW'(1));
    check("err_pkg5_ready", BW'(ready_o), BW'(1));
    check("err_pkg5_bias", bias_o, eb);
    for (int b = 0; b < 4; b++) begin
      valid_i = 1'b1; data_i = e3[b*DW +: DW]; tick();
    end
    valid_i = 1'b0;
    check("load3_loaded", BW'(loaded_o), BW'(1));
    check("load3_bias", bias_o, pp ? e2 : e3);

    // Start and swap in the same FULL cycle.
    start_i = 1'b1; swap_i = 1'b1; pkg_num_i = 3'd1; tick(); start_i = 1'b0; swap_i = 1'b0;
    check("ss_bias", bias_o, pp ? e3 : zero);
    check("ss_ready", BW'(ready_o), BW'(1));
    check("ss_loaded", BW'(loaded_o), BW'(0));
    check("ss_err", BW'(err_o), BW'(0));
    valid_i = 1'b1; data_i = e4[DW-1:0]; tick(); valid_i = 1'b0;
    check("load4_bias", bias_o, pp ? e3 : e4);
    check("load4_loaded", BW'(loaded_o), BW'(1));
    swap_i = 1'b1; tick(); swap_i = 1'b0;
    check("swap4_bias", bias_o, e4);

    // Asynchronous reset in the middle of a load.
    start_i = 1'b1; pkg_num_i = 3'd4; tick(); start_i = 1'b0;
    valid_i = 1'b1; data_i = e3[DW-1:0]; tick(); data_i = e3[2*DW-1:DW]; tick(); valid_i = 1'b0;
    #2 rstn_i = 1'b0;
    #1;
    check("mid_rst_bias", bias_o, zero);
    check("mid_rst_ready", BW'(ready_o), BW'(0));
    check("mid_rst_loaded", BW'(loaded_o), BW'(0));
    check("mid_rst_err", BW'(err_o), BW'(0));
    tick();
    rstn_i = 1'b1;
    tick();
    check("post_rst_ready", BW'(ready_o), BW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
